pll_lock_clkgen: RTL

PLL_LOCK_CLKGEN -- requirements
Module: pll_lock_clkgen

---
 rtl/clkgen_pkg.sv | 13 +
 rtl/ce_divider.sv | 38 +++
 rtl/pll_lock_clkgen.sv | 107 ++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the PLL lock qualifier and clock-enable generator.
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } clk_state_e;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: active divisor plus phase counter, strobing once every N enabled cycles.
module ce_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_comb begin
        // Divisors 0 and 1 both mean "strobe every enabled cycle".
        hit   = (div_q < DIV_W'(2)) || (cnt_q == div_q - DIV_W'(1));
        div_d = load_i ? div_i : div_q;
        cnt_d = '0;
        if (en_i && !load_i && !hit) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        ce_o = en_i && !load_i && hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= DIV_W'(1);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pll_lock_clkgen.sv
// Qualifies the raw PLL lock and releases ready / per-channel clock enables only after a
// sustained lock; counts lock losses seen while running.
module pll_lock_clkgen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DIV_W           = 16,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_lock,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic                    div_load,
    output logic                    ready,
    output logic                    rst_out,
    output logic [NUM_CH-1:0]       ce,
    output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

    // state     | meaning
    // WAIT_LOCK | synchronised lock low, stable counter held at 0
    // STABLE    | lock seen, counting consecutive locked cycles
    // RUN       | clock qualified, ready and clock enables active

    localparam int STAB_W = $clog2(LOCK_STABLE_CYC);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    clk_state_e             state_q, state_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   ready_q, ready_d;
    logic [LOSS_CNT_W-1:0]  loss_q, loss_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            state_q <= state_d;
            stab_q  <= stab_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_s) state_d = STABLE;
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // ready is registered from "in RUN and still locked" so it falls on the same edge the FSM
    // leaves RUN, and rises one cycle after RUN entry.
    always_comb begin
        stab_d  = '0;
        ready_d = 1'b0;
        loss_d  = loss_q;
        case (state_q)
            STABLE: stab_d = lock_s ? stab_q + 1'b1 : '0;
            RUN: begin
                ready_d = lock_s;
                if (!lock_s && (loss_q != LOSS_CNT_MAX)) begin
                    loss_d = loss_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_divider #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (ready_q),
            .load_i (div_load),
            .div_i  (div_val[i*DIV_W +: DIV_W]),
            .ce_o   (ce[i])
        );
    end

    assign ready         = ready_q;
    assign rst_out       = ~ready_q;
    assign lock_loss_cnt = loss_q;

endmodule
